// File: rtl/seven_seg_digit_driver_pkg.sv
// Package for the seven-segment digit driver: shared constants plus the
// anode-to-digit-index helper used by the top level.
package seven_seg_digit_driver_pkg;

  `include "seven_seg_defs.vh"

  // Result of interpreting the scanner's anode vector.
  typedef struct packed {
    logic       valid;  // exactly one anode bit is low
    logic [1:0] idx;    // selected digit, 0 = rightmost
  } digit_sel_t;

  // Only a single low bit selects a digit; any other pattern is invalid.
  function automatic digit_sel_t decode_anode(input logic [3:0] anode);
    digit_sel_t sel;
    sel = '{valid: 1'b0, idx: 2'd0};
    case (anode)
      4'b1110: sel = '{valid: 1'b1, idx: 2'd0};
      4'b1101: sel = '{valid: 1'b1, idx: 2'd1};
      4'b1011: sel = '{valid: 1'b1, idx: 2'd2};
      4'b0111: sel = '{valid: 1'b1, idx: 2'd3};
      default: sel = '{valid: 1'b0, idx: 2'd0};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seven_seg_defs.vh
// Shared seven-segment constants: blank pattern, anode-off pattern and the
// active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
`ifndef SEVEN_SEG_DEFS_VH
`define SEVEN_SEG_DEFS_VH

localparam logic [6:0] SEG_BLANK = 7'h7F;
localparam logic [3:0] ANODE_OFF = 4'hF;

localparam logic [6:0] SEG_HEX_0 = 7'h40;
localparam logic [6:0] SEG_HEX_1 = 7'h79;
localparam logic [6:0] SEG_HEX_2 = 7'h24;
localparam logic [6:0] SEG_HEX_3 = 7'h30;
localparam logic [6:0] SEG_HEX_4 = 7'h19;
localparam logic [6:0] SEG_HEX_5 = 7'h12;
localparam logic [6:0] SEG_HEX_6 = 7'h02;
localparam logic [6:0] SEG_HEX_7 = 7'h78;
localparam logic [6:0] SEG_HEX_8 = 7'h00;
localparam logic [6:0] SEG_HEX_9 = 7'h10;
localparam logic [6:0] SEG_HEX_A = 7'h08;
localparam logic [6:0] SEG_HEX_B = 7'h03;
localparam logic [6:0] SEG_HEX_C = 7'h46;
localparam logic [6:0] SEG_HEX_D = 7'h21;
localparam logic [6:0] SEG_HEX_E = 7'h06;
localparam logic [6:0] SEG_HEX_F = 7'h0E;

`endif

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seven_seg_hex_decode
  import seven_seg_digit_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the glyph for one hex digit.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_digit_driver.sv
// Seven-segment digit driver: shadows value/dp on load, decodes the digit
// picked by the scanner's anode and drives registered anode/cathode/dp.
// Optional blinking is compiled in when SEG_BLINK_EN is defined.
module seven_seg_digit_driver
  import seven_seg_digit_driver_pkg::*;
#(
  parameter int BLINK_DIV = 250
) (
  input  logic        div_clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        lz_blank,
  input  logic        blink_en,
  output logic [3:0]  anode_out,
  output logic [6:0]  cathode,
  output logic        dp_n,
  output logic        load_ack
);

  logic [15:0] value_q;
  logic [3:0]  dp_q;
  logic        load_ack_q;
  logic [3:0]  anode_q,   anode_d;
  logic [6:0]  cathode_q, cathode_d;
  logic        dp_n_q,    dp_n_d;

  digit_sel_t  sel;
  logic [3:0]  digit_nibble;
  logic [6:0]  digit_seg;
  logic [3:0]  lead_zero;
  logic        blink_force;

  // Digit k is a leading zero when every digit from the top down to k is 0.
  assign lead_zero[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
    assign lead_zero[gi] = (value_q[15:4*gi] == '0);
  end

`ifdef SEG_BLINK_EN
  logic [15:0] blink_cnt_q;
  logic        blink_phase_q;

  // Free-running half-period counter; the phase flips on every wrap.
  always_ff @(posedge div_clock) begin
    if (reset) begin
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == 16'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 16'd1;
    end
  end

  assign blink_force = blink_en & blink_phase_q;
`else
  // Without the blink feature the request input and divider are inert.
  logic unused_blink_en;
  localparam int unused_blink_div = BLINK_DIV;
  assign unused_blink_en = blink_en;
  assign blink_force     = 1'b0;
`endif

  assign sel          = decode_anode(anode);
  assign digit_nibble = value_q[{sel.idx, 2'b00} +: 4];

  seven_seg_hex_decode u_hex_decode (
    .hex (digit_nibble),
    .seg (digit_seg)
  );

  // Next output pattern: blank on invalid anode or blink-off phase,
  // otherwise the glyph (or leading-zero blank) plus the digit's dp.
  always_comb begin
    anode_d   = ANODE_OFF;
    cathode_d = SEG_BLANK;
    dp_n_d    = 1'b1;
    if (sel.valid && !blink_force) begin
      anode_d   = anode;
      cathode_d = (lz_blank && lead_zero[sel.idx]) ? SEG_BLANK : digit_seg;
      dp_n_d    = ~dp_q[sel.idx];
    end
  end

  // Shadow registers, load acknowledge and registered display outputs.
  always_ff @(posedge div_clock) begin
    if (reset) begin
      value_q    <= 16'h0000;
      dp_q       <= 4'h0;
      load_ack_q <= 1'b0;
      anode_q    <= ANODE_OFF;
      cathode_q  <= SEG_BLANK;
      dp_n_q     <= 1'b1;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp;
      end
      load_ack_q <= load;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign anode_out = anode_q;
  assign cathode   = cathode_q;
  assign dp_n      = dp_n_q;
  assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Self-checking bench for seven_seg_digit_driver (BLINK_DIV=4).
module tb_seven_seg_digit_driver;

  localparam int BLINK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_blank;
  logic        blink_en;
  logic [3:0]  anode_out;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        load_ack;

  always #5 clk = ~clk;

  seven_seg_digit_driver #(.BLINK_DIV(BLINK)) dut (
    .div_clock (clk),
    .reset     (reset),
    .anode     (anode),
    .value     (value),
    .dp        (dp),
    .load      (load),
    .lz_blank  (lz_blank),
    .blink_en  (blink_en),
    .anode_out (anode_out),
    .cathode   (cathode),
    .dp_n      (dp_n),
    .load_ack  (load_ack)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [6:0]  hex_tbl [16];
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int          m_cyc;
  logic [3:0]  e_anode;
  logic [6:0]  e_cath;
  logic        e_dpn;
  logic        e_ack;

  typedef struct {
    logic [3:0]  anode;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz;
    logic [3:0]  x_anode;
    logic [6:0]  x_cath;
    logic        x_dpn;
    logic        x_ack;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] xa, input logic [6:0] xc,
                         input logic xd, input logic xk);
    chk({nm, ".anode"},   16'(anode_out), 16'(xa));
    chk({nm, ".cathode"}, 16'(cathode),   16'(xc));
    chk({nm, ".dp_n"},    16'(dp_n),      16'(xd));
    chk({nm, ".ack"},     16'(load_ack),  16'(xk));
  endtask

  // Predict the outputs for the current inputs from the display rules,
  // advance the model, then clock once and settle.
  task automatic tick();
    int  k;
    int  zeros;
    bit  blink_off;
    if (reset) begin
      e_anode = 4'hF; e_cath = 7'h7F; e_dpn = 1'b1; e_ack = 1'b0;
    end else begin
      k = 0; zeros = 0;
      for (int i = 0; i < 4; i++) if (!anode[i]) begin zeros++; k = i; end
`ifdef SEG_BLINK_EN
      blink_off = blink_en && (((m_cyc / BLINK) % 2) == 1);
`else
      blink_off = 1'b0;
`endif
      if (zeros != 1 || blink_off) begin
        e_anode = 4'hF; e_cath = 7'h7F; e_dpn = 1'b1;
      end else begin
        e_anode = anode;
        if (lz_blank && k > 0 && (m_val >> (4 * k)) == 0) e_cath = 7'h7F;
        else e_cath = hex_tbl[(m_val >> (4 * k)) & 16'hF];
        e_dpn = !m_dp[k];
      end
      e_ack = load;
    end
    if (reset) begin
      m_val = 16'h0; m_dp = 4'h0; m_cyc = 0;
    end else begin
      if (load) begin m_val = value; m_dp = dp; end
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_val = 16'h0; m_dp = 4'h0; m_cyc = 0;

    // anode, value, dp, load, lz -> anode_out, cathode, dp_n, load_ack
    tbl[0]  = '{4'hF, 16'hA5C0, 4'b0010, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1};
    tbl[1]  = '{4'hE, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hE, 7'h40, 1'b1, 1'b0};
    tbl[2]  = '{4'hD, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hD, 7'h46, 1'b0, 1'b0};
    tbl[3]  = '{4'hB, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hB, 7'h12, 1'b1, 1'b0};
    tbl[4]  = '{4'h7, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'h7, 7'h08, 1'b1, 1'b0};
    tbl[5]  = '{4'h7, 16'h0005, 4'b0000, 1'b1, 1'b1, 4'h7, 7'h08, 1'b1, 1'b1};
    tbl[6]  = '{4'h7, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0};
    tbl[7]  = '{4'hB, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'hB, 7'h7F, 1'b1, 1'b0};
    tbl[8]  = '{4'hD, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0};
    tbl[9]  = '{4'hE, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'hE, 7'h12, 1'b1, 1'b0};
    tbl[10] = '{4'hE, 16'h0000, 4'b0000, 1'b1, 1'b1, 4'hE, 7'h12, 1'b1, 1'b1};
    tbl[11] = '{4'hE, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'hE, 7'h40, 1'b1, 1'b0};
    tbl[12] = '{4'hD, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0};
    tbl[13] = '{4'hF, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[14] = '{4'hC, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[15] = '{4'h0, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[16] = '{4'h7, 16'h0000, 4'b1000, 1'b1, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b1};
    tbl[17] = '{4'h7, 16'h0000, 4'b0000, 1'b0, 1'b1, 4'h7, 7'h7F, 1'b0, 1'b0};

    reset = 1'b1; anode = 4'hF; value = 16'h1234; dp = 4'hF;
    load = 1'b1; lz_blank = 1'b0; blink_en = 1'b0;

    // Reset held 3 cycles with a coincident load
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("reset%0d", i), 4'hF, 7'h7F, 1'b1, 1'b0);
      $display("reset cycle %0d: anode_out=%h cathode=%h ack=%b", i, anode_out, cathode, load_ack);
    end

    // First cycle after release decodes value_q=0 (load was discarded)
    reset = 1'b0; load = 1'b0; anode = 4'hE;
    tick();
    chk_out("post_reset", 4'hE, 7'h40, 1'b1, 1'b0);
    $display("post reset: anode_out=%h cathode=%h", anode_out, cathode);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      anode = tbl[i].anode; value = tbl[i].value; dp = tbl[i].dp;
      load = tbl[i].load; lz_blank = tbl[i].lz;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].x_anode, tbl[i].x_cath, tbl[i].x_dpn, tbl[i].x_ack);
      $display("vec %0d: anode=%h value=%h load=%b -> anode_out=%h cathode=%h dp_n=%b ack=%b",
               i, tbl[i].anode, tbl[i].value, tbl[i].load, anode_out, cathode, dp_n, load_ack);
    end

    // Back-to-back loads: ack stays high, display trails by one load
    lz_blank = 1'b0; anode = 4'hE; dp = 4'h0;
    load = 1'b1; value = 16'h1111; tick();
    chk_out("b2b0", 4'hE, 7'h40, 1'b1, 1'b1);
    value = 16'h2222; tick();
    chk_out("b2b1", 4'hE, 7'h79, 1'b1, 1'b1);
    value = 16'h3333; tick();
    chk_out("b2b2", 4'hE, 7'h24, 1'b1, 1'b1);
    load = 1'b0; value = 16'h0000; tick();
    chk_out("b2b3", 4'hE, 7'h30, 1'b1, 1'b0);
    $display("back-to-back: final cathode=%h ack=%b", cathode, load_ack);

    // Blink sequence: 4 active cycles with blink off, then 16 with blink on
    reset = 1'b1; tick(); reset = 1'b0;
    anode = 4'hE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("blink_pre%0d", i), 4'hE, 7'h40, 1'b1, 1'b0);
    end
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
`ifdef SEG_BLINK_EN
      if (((i / 4) % 2) == 0) chk_out($sformatf("blink%0d", i), 4'hF, 7'h7F, 1'b1, 1'b0);
      else chk_out($sformatf("blink%0d", i), 4'hE, 7'h40, 1'b1, 1'b0);
`else
      chk_out($sformatf("blink%0d", i), 4'hE, 7'h40, 1'b1, 1'b0);
`endif
      $display("blink cycle %0d: anode_out=%h cathode=%h", i, anode_out, cathode);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) < 3);
      value    = 16'($urandom);
      dp       = 4'($urandom);
      lz_blank = 1'($urandom);
      blink_en = 1'($urandom);
      if ($urandom_range(0, 99) < 85) anode = ~(4'b0001 << $urandom_range(0, 3));
      else anode = 4'($urandom);
      tick();
      chk_out($sformatf("rnd%0d", i), e_anode, e_cath, e_dpn, e_ack);
      $display("rnd %0d: rst=%b anode=%h load=%b lz=%b -> anode_out=%h cathode=%h dp_n=%b ack=%b",
               i, reset, anode, load, lz_blank, anode_out, cathode, dp_n, load_ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_digit_driver.md
SEVEN_SEG_DIGIT_DRIVER -- requirements
Module: seven_seg_digit_driver

Interface
REQ-001 SHALL have parameter: BLINK_DIV, 250, div_clock cycles per blink half-period; legal range 2..65535.
REQ-002 SHALL have port: div_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: anode  input  4  active-low one-hot digit select from the scanner; bit0 is the rightmost digit.
REQ-005 SHALL have port: value  input  16  four hex digits; [3:0] is the rightmost digit.
REQ-006 SHALL have port: dp  input  4  decimal-point enables, active-high, one bit per digit.
REQ-007 SHALL have port: load  input  1  captures value and dp into the shadow registers.
REQ-008 SHALL have port: lz_blank  input  1  enables leading-zero blanking.
REQ-009 SHALL have port: blink_en  input  1  requests blinking; ignored when SEG_BLINK_EN is undefined.
REQ-010 SHALL have port: anode_out  output  4  registered, active-low anode drive.
REQ-011 SHALL have port: cathode  output  7  registered, active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port: dp_n  output  1  registered, active-low decimal point.
REQ-013 SHALL have port: load_ack  output  1  one-cycle pulse confirming a capture.

Function
REQ-014 SHALL capture value into value_q and dp into dp_q on every cycle in which load=1.
REQ-015 SHALL assert load_ack in the cycle after each load cycle; back-to-back loads SHALL keep load_ack high continuously.
REQ-016 SHALL decode the digit selected by the current anode from value_q, and SHALL present the result, together with anode_out=anode, exactly one cycle later.
REQ-017 SHALL NOT show a same-cycle load in that cycle's decode; the loaded data SHALL appear on the next output update.
REQ-018 SHALL decode hex to segments as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, 7-bit, active-low).
REQ-019 SHALL treat any anode that is not exactly one zero bit (e.g. 4'hF, 4'h0, 4'b1100) as invalid, and SHALL then output anode_out=4'hF, cathode=7'h7F and dp_n=1.
REQ-020 SHALL blank digit k (k=3..1) when lz_blank=1 and value_q digits 3..k are all zero, giving cathode=7'h7F with anode_out still driven.
REQ-021 SHALL never blank digit 0, so a zero value displays as "0".
REQ-022 SHALL drive dp_n=~dp_q[k] for the selected digit k, independent of leading-zero blanking.

Reset
REQ-023 SHALL, while reset=1, force value_q=16'h0, dp_q=4'h0, anode_out=4'hF, cathode=7'h7F, dp_n=1, load_ack=0, blink counter=0 and blink phase=0.
REQ-024 SHALL give reset priority over a coincident load; the captured value is discarded and load_ack stays 0.
REQ-025 SHALL, on the first cycle after reset is released, resume normal decoding of value_q=0.

Configuration
REQ-026 SHALL, when SEG_BLINK_EN is defined, include a 16-bit counter that wraps at BLINK_DIV-1 and toggles the blink phase on each wrap.
REQ-027 SHALL, when SEG_BLINK_EN is defined, force the blank output pattern of REQ-019 while blink_en=1 and phase=1.
REQ-028 SHALL keep the blink counter free-running regardless of the blink_en value.
REQ-029 SHALL, when SEG_BLINK_EN is undefined, omit the counter, ignore blink_en, and never blink.

Structure
REQ-030 SHALL place the segment constants (SEG_BLANK=7'h7F and the hex table) and the ANODE_OFF=4'hF constant in the shared include seven_seg_defs.vh.
REQ-031 SHALL implement hex-to-segment conversion as a combinational sub-module seven_seg_hex_decode (4 in, 7 out), instantiated once.

Verification
REQ-032 SHALL cover: reset held 3 cycles with load=1 and value=16'h1234 -> anode_out=F, cathode=7F, load_ack=0 throughout.
REQ-033 SHALL cover: load value=16'hA5C0 and dp=4'b0010, then sweep anode E,D,B,7 -> next-cycle cathode 40,46,12,08; dp_n=0 only when anode_out=D.
REQ-034 SHALL cover: lz_blank=1 with value=16'h0005, then 16'h0000 -> digits 3..1 show 7F, digit0 shows 12 then 40.
REQ-035 SHALL cover: anode=F, then anode=C -> anode_out=F and cathode=7F one cycle later in each case.
REQ-036 SHALL cover: load held high for 3 cycles with a changing value -> load_ack high for 3 cycles starting one cycle later, and the display shows the last value.
REQ-037 SHALL cover, with SEG_BLINK_EN defined, BLINK_DIV=4 and blink_en=1: outputs blank for 4 cycles, then active for 4 cycles, repeating; with the macro undefined, the outputs never blank.
